writeback_stage: RTL and testbench

- MEM/WB pipeline register plus write-back formatter, directly upstream of the register file.
- Latches the MEM-stage result and selects the write-back source (ALU, load data, or link address).
- Formats sub-word loads and drives reg_write, write_reg_addr and write_data into the register file.
- Also maintains a retired-instruction counter for performance and debug.

---
 rtl/writeback_stage_pkg.sv | 35 +++
 rtl/writeback_stage_if.sv | 44 ++++
 rtl/writeback_stage_load_formatter.sv | 36 +++
 rtl/writeback_stage.sv | 65 ++++++
 tb/tb_writeback_stage.sv | 210 +++++++++++++++++++++
 5 files changed

// File: rtl/writeback_stage_pkg.sv
// Shared write-back definitions: source selects, load types,
// reset constants and the latched WB entry.
package writeback_stage_pkg;

  localparam logic [1:0] WB_SEL_ALU  = 2'b00;
  localparam logic [1:0] WB_SEL_MEM  = 2'b01;
  localparam logic [1:0] WB_SEL_LINK = 2'b10;
  localparam logic [1:0] WB_SEL_NONE = 2'b11;

  localparam logic [2:0] LD_W  = 3'd0;
  localparam logic [2:0] LD_H  = 3'd1;
  localparam logic [2:0] LD_HU = 3'd2;
  localparam logic [2:0] LD_B  = 3'd3;
  localparam logic [2:0] LD_BU = 3'd4;

  localparam logic [31:0] INIT_32 = 32'h0;
  localparam logic [4:0]  INIT_5  = 5'h0;

  typedef struct packed {
    logic        valid;
    logic        reg_write;
    logic [4:0]  addr;
    logic [31:0] data;
    logic [31:0] pc;
  } wb_entry_t;

  localparam wb_entry_t WB_BUBBLE = '{
    valid:     1'b0,
    reg_write: 1'b0,
    addr:      INIT_5,
    data:      INIT_32,
    pc:        INIT_32
  };

endpackage

// File: rtl/writeback_stage_if.sv
// MEM-side inputs and register-file-side outputs of
// the write-back stage, grouped for port hookup.
interface writeback_stage_if #(
  parameter int CNT_WIDTH = 32
);

  logic                 stall;
  logic                 flush;
  logic                 mem_valid;
  logic                 mem_reg_write;
  logic [4:0]           mem_write_reg_addr;
  logic [1:0]           mem_wb_sel;
  logic [2:0]           mem_load_type;
  logic [1:0]           mem_byte_offset;
  logic [31:0]          mem_alu_result;
  logic [31:0]          mem_read_data;
  logic [31:0]          mem_pc;

  logic                 reg_write;
  logic [4:0]           write_reg_addr;
  logic [31:0]          write_data;
  logic                 wb_valid;
  logic [31:0]          wb_pc;
  logic [CNT_WIDTH-1:0] retired_count;

  modport master (
    output stall, flush, mem_valid, mem_reg_write,
    output mem_write_reg_addr, mem_wb_sel,
    output mem_load_type, mem_byte_offset,
    output mem_alu_result, mem_read_data, mem_pc,
    input  reg_write, write_reg_addr, write_data,
    input  wb_valid, wb_pc, retired_count
  );

  modport slave (
    input  stall, flush, mem_valid, mem_reg_write,
    input  mem_write_reg_addr, mem_wb_sel,
    input  mem_load_type, mem_byte_offset,
    input  mem_alu_result, mem_read_data, mem_pc,
    output reg_write, write_reg_addr, write_data,
    output wb_valid, wb_pc, retired_count
  );

endinterface

// File: rtl/writeback_stage_load_formatter.sv
// Sub-word load extraction and extension of the raw
// little-endian memory word.
module load_formatter
  import writeback_stage_pkg::*;
(
  input  logic [31:0] raw_data,
  input  logic [2:0]  load_type,
  input  logic [1:0]  byte_offset,
  output logic [31:0] data_out
);

  logic [7:0]  sel_byte;
  logic [15:0] sel_half;

  // pick the addressed byte/half, then extend by load type
  always_comb begin
    sel_byte = raw_data[7:0];
    unique case (byte_offset)
      2'd0: sel_byte = raw_data[7:0];
      2'd1: sel_byte = raw_data[15:8];
      2'd2: sel_byte = raw_data[23:16];
      2'd3: sel_byte = raw_data[31:24];
      default: sel_byte = raw_data[7:0];
    endcase
    sel_half = byte_offset[1] ? raw_data[31:16]
                              : raw_data[15:0];
    unique case (load_type)
      LD_H:    data_out = {{16{sel_half[15]}}, sel_half};
      LD_HU:   data_out = {16'h0, sel_half};
      LD_B:    data_out = {{24{sel_byte[7]}}, sel_byte};
      LD_BU:   data_out = {24'h0, sel_byte};
      default: data_out = raw_data;
    endcase
  end

endmodule

// File: rtl/writeback_stage.sv
// MEM/WB pipeline register with write-back source mux,
// load formatting and a retired-instruction counter.
module writeback_stage
  import writeback_stage_pkg::*;
#(
  parameter int          CNT_WIDTH   = 32,
  parameter logic [31:0] LINK_OFFSET = 32'd8
) (
  input logic              clk,
  input logic              rst,
  writeback_stage_if.slave bus
);

  logic [31:0]          load_data;
  wb_entry_t            next_e;
  wb_entry_t            cur_e;
  logic [CNT_WIDTH-1:0] count;

  load_formatter u_fmt (
    .raw_data    (bus.mem_read_data),
    .load_type   (bus.mem_load_type),
    .byte_offset (bus.mem_byte_offset),
    .data_out    (load_data)
  );

  // build the entry to latch from the MEM-side inputs
  always_comb begin
    next_e       = WB_BUBBLE;
    next_e.valid = bus.mem_valid;
    next_e.addr  = bus.mem_write_reg_addr;
    next_e.pc    = bus.mem_pc;
    unique case (bus.mem_wb_sel)
      WB_SEL_ALU:  next_e.data = bus.mem_alu_result;
      WB_SEL_MEM:  next_e.data = load_data;
      WB_SEL_LINK: next_e.data = bus.mem_pc + LINK_OFFSET;
      default:     next_e.data = INIT_32;
    endcase
    next_e.reg_write = bus.mem_valid
                     & bus.mem_reg_write
                     & (bus.mem_write_reg_addr != INIT_5)
                     & (bus.mem_wb_sel != WB_SEL_NONE);
  end

  // WB latch and retire counter: flush beats stall
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cur_e <= WB_BUBBLE;
      count <= '0;
    end else if (bus.flush) begin
      cur_e <= WB_BUBBLE;
    end else if (!bus.stall) begin
      cur_e <= next_e;
      if (bus.mem_valid)
        count <= count + CNT_WIDTH'(1);
    end
  end

  assign bus.reg_write      = cur_e.reg_write;
  assign bus.write_reg_addr = cur_e.addr;
  assign bus.write_data     = cur_e.data;
  assign bus.wb_valid       = cur_e.valid;
  assign bus.wb_pc          = cur_e.pc;
  assign bus.retired_count  = count;

endmodule

// File: tb/tb_writeback_stage.sv
// Self-checking bench for writeback_stage: directed
// cases from the plan plus randomized traffic.
module tb_writeback_stage;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   failures = 0;

  writeback_stage_if #(.CNT_WIDTH(4)) bus ();

  writeback_stage #(.CNT_WIDTH(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // reference state of the WB latch
  logic        e_valid, e_rw;
  logic [4:0]  e_addr;
  logic [31:0] e_data, e_pc;
  int          e_cnt;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ref_data(
    input logic [1:0] sel, input logic [2:0] lt,
    input logic [1:0] off, input logic [31:0] alu,
    input logic [31:0] rd, input logic [31:0] pc);
    longint u;
    if (sel == 2'd0) return alu;
    if (sel == 2'd2) return pc + 32'd8;
    if (sel == 2'd3) return 32'h0;
    case (lt)
      3'd1, 3'd2: begin
        u = (longint'(rd) >> (off[1] ? 16 : 0)) & 65535;
        if (lt == 3'd1 && u >= 32768) u = u - 65536;
      end
      3'd3, 3'd4: begin
        u = (longint'(rd) >> (8 * int'(off))) & 255;
        if (lt == 3'd3 && u >= 128) u = u - 256;
      end
      default: u = longint'(rd);
    endcase
    return u[31:0];
  endfunction

  task automatic reset_model();
    e_valid = 0; e_rw = 0; e_addr = 0;
    e_data = 0; e_pc = 0; e_cnt = 0;
  endtask

  task automatic set_in(input logic v, input logic rw,
                        input logic [4:0] a,
                        input logic [1:0] sel,
                        input logic [2:0] lt,
                        input logic [1:0] off,
                        input logic [31:0] alu,
                        input logic [31:0] rd,
                        input logic [31:0] pc);
    bus.mem_valid = v;
    bus.mem_reg_write = rw;
    bus.mem_write_reg_addr = a;
    bus.mem_wb_sel = sel;
    bus.mem_load_type = lt;
    bus.mem_byte_offset = off;
    bus.mem_alu_result = alu;
    bus.mem_read_data = rd;
    bus.mem_pc = pc;
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".reg_write"}, 32'(bus.reg_write), 32'(e_rw));
    chk({tag, ".addr"}, 32'(bus.write_reg_addr), 32'(e_addr));
    chk({tag, ".data"}, bus.write_data, e_data);
    chk({tag, ".valid"}, 32'(bus.wb_valid), 32'(e_valid));
    chk({tag, ".pc"}, bus.wb_pc, e_pc);
    chk({tag, ".count"}, 32'(bus.retired_count), 32'(e_cnt));
  endtask

  // one clock: model follows the edge, outputs checked 1ns later
  task automatic step(input string tag);
    @(posedge clk);
    if (bus.flush) begin
      e_valid = 0; e_rw = 0; e_addr = 0;
      e_data = 0; e_pc = 0;
    end else if (!bus.stall) begin
      e_valid = bus.mem_valid;
      e_addr = bus.mem_write_reg_addr;
      e_pc = bus.mem_pc;
      e_data = ref_data(bus.mem_wb_sel, bus.mem_load_type,
                        bus.mem_byte_offset,
                        bus.mem_alu_result,
                        bus.mem_read_data, bus.mem_pc);
      e_rw = bus.mem_valid && bus.mem_reg_write &&
             bus.mem_write_reg_addr != 0 &&
             bus.mem_wb_sel != 2'd3;
      if (bus.mem_valid) e_cnt = (e_cnt + 1) % 16;
    end
    #1;
    check_all(tag);
  endtask

  initial begin
    logic [31:0] rdw;
    logic [31:0] held_d;
    rdw = 32'h80FF7F01;
    bus.stall = 0;
    bus.flush = 0;
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
    reset_model();
    #3;
    check_all("reset");
    @(negedge clk);
    rst = 0;

    // ALU pass-through
    set_in(1, 1, 5, 2'd0, 0, 0, 32'hDEADBEEF, 0, 32'h100);
    step("alu");
    chk("alu.data_const", bus.write_data, 32'hDEADBEEF);
    chk("alu.count_const", 32'(bus.retired_count), 32'd1);

    // async reset mid-cycle with a latched write
    chk("prereset.rw", 32'(bus.reg_write), 32'd1);
    #2 rst = 1;
    #1;
    reset_model();
    check_all("async_reset");
    #1 rst = 0;

    // sub-word loads
    set_in(1, 1, 7, 2'd1, 3'd3, 2'd3, 0, rdw, 32'h200);
    step("ld_b");
    chk("ld_b.const", bus.write_data, 32'hFFFFFF80);
    set_in(1, 1, 7, 2'd1, 3'd4, 2'd3, 0, rdw, 32'h204);
    step("ld_bu");
    chk("ld_bu.const", bus.write_data, 32'h00000080);
    set_in(1, 1, 7, 2'd1, 3'd1, 2'd2, 0, rdw, 32'h208);
    step("ld_h");
    chk("ld_h.const", bus.write_data, 32'hFFFF80FF);
    set_in(1, 1, 7, 2'd1, 3'd2, 2'd1, 0, rdw, 32'h20C);
    step("ld_hu");
    chk("ld_hu.const", bus.write_data, 32'h00007F01);
    set_in(1, 1, 7, 2'd1, 3'd0, 2'd2, 0, rdw, 32'h210);
    step("ld_w");
    chk("ld_w.const", bus.write_data, 32'h80FF7F01);

    // link and $0
    set_in(1, 1, 31, 2'd2, 0, 0, 0, 0, 32'h00400010);
    step("link");
    chk("link.const", bus.write_data, 32'h00400018);
    set_in(1, 1, 0, 2'd2, 0, 0, 0, 0, 32'h00400010);
    step("link_r0");
    chk("link_r0.rw", 32'(bus.reg_write), 32'd0);
    chk("link_r0.count", 32'(bus.retired_count), 32'd7);

    // stall holds, stall+flush gives a bubble
    set_in(1, 1, 9, 2'd0, 0, 0, 32'h12345678, 0, 32'h300);
    step("cap");
    held_d = bus.write_data;
    bus.stall = 1;
    for (int i = 0; i < 3; i++) begin
      set_in(1, 1, 5'(i + 10), 2'd0, 0, 0,
             $urandom, $urandom, $urandom);
      step("stall");
      chk("stall.hold", bus.write_data, held_d);
    end
    bus.flush = 1;
    step("stall_flush");
    chk("flush.valid", 32'(bus.wb_valid), 32'd0);
    bus.stall = 0;
    bus.flush = 0;

    // counter wrap: 17 retires from a clean reset
    rst = 1;
    #1 rst = 0;
    reset_model();
    for (int i = 0; i < 17; i++) begin
      set_in(1, 1, 5'($urandom_range(1, 31)), 2'd0, 0, 0,
             $urandom, 0, $urandom);
      step("wrap");
    end
    chk("wrap.const", 32'(bus.retired_count), 32'd1);

    // random traffic
    for (int i = 0; i < 80; i++) begin
      bus.stall = ($urandom_range(0, 3) == 0);
      bus.flush = ($urandom_range(0, 7) == 0);
      set_in(1'($urandom), 1'($urandom),
             5'($urandom), 2'($urandom), 3'($urandom),
             2'($urandom), $urandom, $urandom, $urandom);
      step("rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
